scarv_cop_mem_arb: RTL and testbench



---
 rtl/scarv_cop_mem_arb_pkg.sv | 31 +++
 rtl/scarv_cop_mem_arb_sel.sv | 29 ++
 rtl/scarv_cop_mem_arb.sv | 123 ++++++++++++
 tb/tb_scarv_cop_mem_arb.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/scarv_cop_mem_arb_pkg.sv
// Shared owner encodings, arbitration modes and request bundle for the
// CPU/COP memory port arbiter.
package scarv_cop_mem_arb_pkg;

   localparam logic [1:0] ARB_OWN_NONE = 2'd0;
   localparam logic [1:0] ARB_OWN_CPU  = 2'd1;
   localparam logic [1:0] ARB_OWN_COP  = 2'd2;

   localparam int ARB_MODE_RR    = 0;
   localparam int ARB_MODE_FIXED = 1;

   typedef struct packed {
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  ben;
   } mem_req_t;

   function automatic mem_req_t make_req(input logic        wen,
                                         input logic [31:0] addr,
                                         input logic [31:0] wdata,
                                         input logic [3:0]  ben);
      mem_req_t r;
      r.wen   = wen;
      r.addr  = addr;
      r.wdata = wdata;
      r.ben   = ben;
      return r;
   endfunction

endpackage

// File: rtl/scarv_cop_mem_arb_sel.sv
// Combinational winner select between the CPU and COP requesters.
module scarv_cop_mem_arb_sel
   import scarv_cop_mem_arb_pkg::*;
#(
   parameter int ARB_MODE = ARB_MODE_RR
) (
   input  logic       i_cpu_cen,
   input  logic       i_cop_cen,
   input  logic [1:0] i_rr_last,
   output logic [1:0] o_winner
);

   // NOTE: o_winner gets a default first so no path through this block can infer a latch.
   always_comb begin
      o_winner = ARB_OWN_NONE;
      if (i_cpu_cen && i_cop_cen) begin
         if (ARB_MODE == ARB_MODE_FIXED) begin
            o_winner = ARB_OWN_COP;
         end else begin
            o_winner = (i_rr_last == ARB_OWN_CPU) ? ARB_OWN_COP : ARB_OWN_CPU;
         end
      end else if (i_cpu_cen) begin
         o_winner = ARB_OWN_CPU;
      end else if (i_cop_cen) begin
         o_winner = ARB_OWN_COP;
      end
   end

endmodule

// File: rtl/scarv_cop_mem_arb.sv
// Shares one SoC memory port between the core data port and the coprocessor
// load/store port; responses are routed combinationally through the owner register.
module scarv_cop_mem_arb
   import scarv_cop_mem_arb_pkg::*;
#(
   parameter int ARB_MODE = ARB_MODE_RR,
   parameter int CNT_W    = 16
) (
   input  logic             g_clk,
   input  logic             g_resetn,

   input  logic             cpu_cen,
   input  logic             cpu_wen,
   input  logic [31:0]      cpu_addr,
   input  logic [31:0]      cpu_wdata,
   input  logic [3:0]       cpu_ben,
   output logic [31:0]      cpu_rdata,
   output logic             cpu_stall,
   output logic             cpu_error,

   input  logic             cop_cen,
   input  logic             cop_wen,
   input  logic [31:0]      cop_addr,
   input  logic [31:0]      cop_wdata,
   input  logic [3:0]       cop_ben,
   output logic [31:0]      cop_rdata,
   output logic             cop_stall,
   output logic             cop_error,

   output logic             mem_cen,
   output logic             mem_wen,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic [3:0]       mem_ben,
   input  logic [31:0]      mem_rdata,
   input  logic             mem_stall,
   input  logic             mem_error,

   output logic [CNT_W-1:0] arb_conflicts
);

   logic [1:0]       r_owner;
   logic [1:0]       r_rr_last;
   logic [CNT_W-1:0] r_conflicts;

   logic       w_issue_window;
   logic [1:0] w_sel_winner;
   logic [1:0] w_winner;
   logic       w_conflict;
   logic       w_cpu_owns;
   logic       w_cop_owns;
   mem_req_t   w_cpu_req;
   mem_req_t   w_cop_req;
   mem_req_t   w_mem_req;

   scarv_cop_mem_arb_sel #(
      .ARB_MODE (ARB_MODE)
   ) u_sel (
      .i_cpu_cen (cpu_cen),
      .i_cop_cen (cop_cen),
      .i_rr_last (r_rr_last),
      .o_winner  (w_sel_winner)
   );

   // Nothing is issued while reset is held, so the port is quiet even if a
   // requester keeps cen asserted across an asynchronous reset.
   assign w_issue_window = g_resetn && ((r_owner == ARB_OWN_NONE) || !mem_stall);
   assign w_winner       = w_issue_window ? w_sel_winner : ARB_OWN_NONE;

   assign w_cpu_req = make_req(cpu_wen, cpu_addr, cpu_wdata, cpu_ben);
   assign w_cop_req = make_req(cop_wen, cop_addr, cop_wdata, cop_ben);

   always_comb begin
      w_mem_req = '0;
      case (w_winner)
         ARB_OWN_CPU: w_mem_req = w_cpu_req;
         ARB_OWN_COP: w_mem_req = w_cop_req;
         default:     w_mem_req = '0;
      endcase
   end

   assign mem_cen   = (w_winner != ARB_OWN_NONE);
   assign mem_wen   = w_mem_req.wen;
   assign mem_addr  = w_mem_req.addr;
   assign mem_wdata = w_mem_req.wdata;
   assign mem_ben   = w_mem_req.ben;

   assign w_cpu_owns = (r_owner == ARB_OWN_CPU);
   assign w_cop_owns = (r_owner == ARB_OWN_COP);

   assign cpu_stall = w_cpu_owns ? mem_stall : 1'b1;
   assign cop_stall = w_cop_owns ? mem_stall : 1'b1;
   assign cpu_rdata = (w_cpu_owns && !mem_stall) ? mem_rdata : 32'h0;
   assign cop_rdata = (w_cop_owns && !mem_stall) ? mem_rdata : 32'h0;
   assign cpu_error = w_cpu_owns && !mem_stall && mem_error;
   assign cop_error = w_cop_owns && !mem_stall && mem_error;

   // Counts at most once per cycle, even when both requesters are waiting.
   assign w_conflict = (cpu_cen && (w_winner != ARB_OWN_CPU)) ||
                       (cop_cen && (w_winner != ARB_OWN_COP));

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         r_owner     <= ARB_OWN_NONE;
         r_rr_last   <= ARB_OWN_COP;
         r_conflicts <= '0;
      end else begin
         if (w_issue_window) begin
            r_owner <= w_winner;
            if (w_winner != ARB_OWN_NONE) begin
               r_rr_last <= w_winner;
            end
         end
         if (w_conflict && (r_conflicts != {CNT_W{1'b1}})) begin
            r_conflicts <= r_conflicts + 1'b1;
         end
      end
   end

   assign arb_conflicts = r_conflicts;

endmodule

// File: tb/tb_scarv_cop_mem_arb.sv
// Directed bench for scarv_cop_mem_arb: grants are stated per step, responses
// are checked against a scoreboard of outstanding grants.
module tb_scarv_cop_mem_arb;
   import scarv_cop_mem_arb_pkg::*;

   logic        g_clk;
   logic        g_resetn;
   logic        cpu_cen, cpu_wen, cop_cen, cop_wen;
   logic [31:0] cpu_addr, cpu_wdata, cop_addr, cop_wdata;
   logic [3:0]  cpu_ben, cop_ben;
   logic [31:0] mem_rdata;
   logic        mem_stall, mem_error;

   // Index 0: round-robin, 1: fixed priority, 2: round-robin with 3-bit counter.
   logic        mem_cen_o   [3];
   logic        mem_wen_o   [3];
   logic [31:0] mem_addr_o  [3];
   logic [31:0] mem_wdata_o [3];
   logic [3:0]  mem_ben_o   [3];
   logic [31:0] cpu_rdata_o [3];
   logic [31:0] cop_rdata_o [3];
   logic        cpu_stall_o [3];
   logic        cop_stall_o [3];
   logic        cpu_error_o [3];
   logic        cop_error_o [3];
   logic [15:0] cnt_o       [2];
   logic [2:0]  sat_cnt;

   int          checks   = 0;
   int          failures = 0;
   int          m_cnt    = 0;
   logic        sel_fp   = 1'b0;
   logic [1:0]  sb[$];

   initial g_clk = 1'b0;
   always #5 g_clk = ~g_clk;

   scarv_cop_mem_arb #(.ARB_MODE(ARB_MODE_RR), .CNT_W(16)) u_rr (
      .g_clk(g_clk), .g_resetn(g_resetn),
      .cpu_cen(cpu_cen), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ben(cpu_ben), .cpu_rdata(cpu_rdata_o[0]), .cpu_stall(cpu_stall_o[0]), .cpu_error(cpu_error_o[0]),
      .cop_cen(cop_cen), .cop_wen(cop_wen), .cop_addr(cop_addr), .cop_wdata(cop_wdata),
      .cop_ben(cop_ben), .cop_rdata(cop_rdata_o[0]), .cop_stall(cop_stall_o[0]), .cop_error(cop_error_o[0]),
      .mem_cen(mem_cen_o[0]), .mem_wen(mem_wen_o[0]), .mem_addr(mem_addr_o[0]), .mem_wdata(mem_wdata_o[0]),
      .mem_ben(mem_ben_o[0]), .mem_rdata(mem_rdata), .mem_stall(mem_stall), .mem_error(mem_error),
      .arb_conflicts(cnt_o[0])
   );

   scarv_cop_mem_arb #(.ARB_MODE(ARB_MODE_FIXED), .CNT_W(16)) u_fp (
      .g_clk(g_clk), .g_resetn(g_resetn),
      .cpu_cen(cpu_cen), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ben(cpu_ben), .cpu_rdata(cpu_rdata_o[1]), .cpu_stall(cpu_stall_o[1]), .cpu_error(cpu_error_o[1]),
      .cop_cen(cop_cen), .cop_wen(cop_wen), .cop_addr(cop_addr), .cop_wdata(cop_wdata),
      .cop_ben(cop_ben), .cop_rdata(cop_rdata_o[1]), .cop_stall(cop_stall_o[1]), .cop_error(cop_error_o[1]),
      .mem_cen(mem_cen_o[1]), .mem_wen(mem_wen_o[1]), .mem_addr(mem_addr_o[1]), .mem_wdata(mem_wdata_o[1]),
      .mem_ben(mem_ben_o[1]), .mem_rdata(mem_rdata), .mem_stall(mem_stall), .mem_error(mem_error),
      .arb_conflicts(cnt_o[1])
   );

   scarv_cop_mem_arb #(.ARB_MODE(ARB_MODE_RR), .CNT_W(3)) u_sat (
      .g_clk(g_clk), .g_resetn(g_resetn),
      .cpu_cen(cpu_cen), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ben(cpu_ben), .cpu_rdata(cpu_rdata_o[2]), .cpu_stall(cpu_stall_o[2]), .cpu_error(cpu_error_o[2]),
      .cop_cen(cop_cen), .cop_wen(cop_wen), .cop_addr(cop_addr), .cop_wdata(cop_wdata),
      .cop_ben(cop_ben), .cop_rdata(cop_rdata_o[2]), .cop_stall(cop_stall_o[2]), .cop_error(cop_error_o[2]),
      .mem_cen(mem_cen_o[2]), .mem_wen(mem_wen_o[2]), .mem_addr(mem_addr_o[2]), .mem_wdata(mem_wdata_o[2]),
      .mem_ben(mem_ben_o[2]), .mem_rdata(mem_rdata), .mem_stall(mem_stall), .mem_error(mem_error),
      .arb_conflicts(sat_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      int k;
      k = sel_fp ? 1 : 0;
      check({tag, ".mem_cen"},   32'(mem_cen_o[k]),   32'd0);
      check({tag, ".mem_addr"},  mem_addr_o[k],       32'd0);
      check({tag, ".mem_wdata"}, mem_wdata_o[k],      32'd0);
      check({tag, ".cpu_stall"}, 32'(cpu_stall_o[k]), 32'd1);
      check({tag, ".cop_stall"}, 32'(cop_stall_o[k]), 32'd1);
      check({tag, ".cpu_rdata"}, cpu_rdata_o[k],      32'd0);
      check({tag, ".cop_rdata"}, cop_rdata_o[k],      32'd0);
      check({tag, ".cop_error"}, 32'(cop_error_o[k]), 32'd0);
      check({tag, ".count"},     32'(cnt_o[k]),       32'd0);
   endtask

   // One clock cycle: drive requests and memory response, state the expected
   // grant, check mid-cycle, then update scoreboard and conflict model.
   task automatic cyc(input logic c_cen, input logic p_cen, input logic stall,
                      input logic [31:0] rdata, input logic err, input logic [1:0] grant);
      int          k;
      logic [1:0]  who;
      logic        resp;
      logic        e_wen;
      logic [31:0] e_addr, e_wdata;
      logic [3:0]  e_ben;
      k         = sel_fp ? 1 : 0;
      cpu_cen   = c_cen;
      cop_cen   = p_cen;
      mem_stall = stall;
      mem_rdata = rdata;
      mem_error = err;
      who  = (sb.size() != 0) ? sb[0] : ARB_OWN_NONE;
      resp = (who != ARB_OWN_NONE) && !stall;
      e_wen = 1'b0; e_addr = 32'd0; e_wdata = 32'd0; e_ben = 4'd0;
      if (grant == ARB_OWN_CPU) begin
         e_wen = cpu_wen; e_addr = cpu_addr; e_wdata = cpu_wdata; e_ben = cpu_ben;
      end else if (grant == ARB_OWN_COP) begin
         e_wen = cop_wen; e_addr = cop_addr; e_wdata = cop_wdata; e_ben = cop_ben;
      end
      #3;
      check("mem_cen",   32'(mem_cen_o[k]), 32'(grant != ARB_OWN_NONE));
      check("mem_wen",   32'(mem_wen_o[k]), 32'(e_wen));
      check("mem_addr",  mem_addr_o[k],     e_addr);
      check("mem_wdata", mem_wdata_o[k],    e_wdata);
      check("mem_ben",   32'(mem_ben_o[k]), 32'(e_ben));
      check("cpu_stall", 32'(cpu_stall_o[k]), 32'((who == ARB_OWN_CPU) ? stall : 1'b1));
      check("cop_stall", 32'(cop_stall_o[k]), 32'((who == ARB_OWN_COP) ? stall : 1'b1));
      check("cpu_rdata", cpu_rdata_o[k], (resp && who == ARB_OWN_CPU) ? rdata : 32'd0);
      check("cop_rdata", cop_rdata_o[k], (resp && who == ARB_OWN_COP) ? rdata : 32'd0);
      check("cpu_error", 32'(cpu_error_o[k]), 32'(resp && who == ARB_OWN_CPU && err));
      check("cop_error", 32'(cop_error_o[k]), 32'(resp && who == ARB_OWN_COP && err));
      check("conflicts", 32'(cnt_o[k]), 32'(m_cnt));
      if (!sel_fp) check("conflicts_sat", 32'(sat_cnt), (m_cnt > 7) ? 32'd7 : 32'(m_cnt));
      @(posedge g_clk);
      #1;
      if (resp) void'(sb.pop_front());
      if (grant != ARB_OWN_NONE) sb.push_back(grant);
      if ((c_cen && grant != ARB_OWN_CPU) || (p_cen && grant != ARB_OWN_COP)) m_cnt++;
   endtask

   // Reset asserted and released between clock edges; requests are dropped while in reset.
   task automatic do_reset(input string tag);
      #2;
      g_resetn = 1'b0;
      #1;
      check_idle(tag);
      cpu_cen = 1'b0; cop_cen = 1'b0; cpu_wen = 1'b0; cop_wen = 1'b0;
      mem_stall = 1'b0; mem_error = 1'b0; mem_rdata = 32'd0;
      #2;
      g_resetn = 1'b1;
      sb.delete();
      m_cnt = 0;
      @(posedge g_clk);
      #1;
   endtask

   initial begin
      g_resetn = 1'b0;
      cpu_cen = 1'b0; cpu_wen = 1'b0; cpu_addr = 32'h100; cpu_wdata = 32'd0; cpu_ben = 4'd0;
      cop_cen = 1'b0; cop_wen = 1'b0; cop_addr = 32'h200; cop_wdata = 32'd0; cop_ben = 4'd0;
      mem_rdata = 32'd0; mem_stall = 1'b0; mem_error = 1'b0;
      #1;
      check_idle("reset");
      @(negedge g_clk);
      g_resetn = 1'b1;
      @(posedge g_clk);
      #1;

      // CPU-only write then back-to-back read.
      cpu_wen = 1'b1; cpu_addr = 32'h104; cpu_wdata = 32'hCAFEF00D; cpu_ben = 4'h5;
      cyc(1'b1, 1'b0, 1'b1, 32'h0, 1'b0, ARB_OWN_CPU);
      cpu_wen = 1'b0; cpu_addr = 32'h100; cpu_wdata = 32'h0; cpu_ben = 4'h0;
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, ARB_OWN_CPU);
      cyc(1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0, ARB_OWN_NONE);
      cyc(1'b0, 1'b0, 1'b1, 32'hBAD0BAD0, 1'b0, ARB_OWN_NONE);

      // Simultaneous requests after reset: CPU first, COP back-to-back.
      do_reset("reset2");
      cyc(1'b1, 1'b1, 1'b1, 32'h0, 1'b0, ARB_OWN_CPU);
      cyc(1'b1, 1'b1, 1'b0, 32'h11111111, 1'b0, ARB_OWN_COP);
      cyc(1'b0, 1'b0, 1'b0, 32'h22222222, 1'b0, ARB_OWN_NONE);

      // COP owns and memory stalls for three cycles while CPU waits.
      cyc(1'b0, 1'b1, 1'b1, 32'h0, 1'b0, ARB_OWN_COP);
      repeat (3) cyc(1'b1, 1'b1, 1'b1, 32'hBADBAD00, 1'b0, ARB_OWN_NONE);
      cyc(1'b1, 1'b1, 1'b0, 32'h33333333, 1'b0, ARB_OWN_CPU);
      cyc(1'b0, 1'b0, 1'b0, 32'h44444444, 1'b0, ARB_OWN_NONE);

      // Four-beat COP gather against continuous CPU requests.
      cop_addr = 32'h200;
      cyc(1'b1, 1'b1, 1'b1, 32'h0, 1'b0, ARB_OWN_COP);
      for (int i = 0; i < 4; i++) begin
         cop_addr = 32'h200 + 32'(4 * i);
         cyc(1'b1, 1'b1, 1'b0, 32'hC0DE0000 | 32'(i), 1'b0, ARB_OWN_CPU);
         cop_addr = 32'h204 + 32'(4 * i);
         cyc(i < 3, i < 3, 1'b0, 32'hA0000000 | 32'(i), 1'b0,
             (i < 3) ? ARB_OWN_COP : ARB_OWN_NONE);
      end

      // Fixed priority: COP wins every tie, error routed to COP only.
      do_reset("reset3");
      sel_fp = 1'b1;
      cyc(1'b1, 1'b1, 1'b1, 32'h0, 1'b0, ARB_OWN_COP);
      cyc(1'b1, 1'b1, 1'b0, 32'h55555555, 1'b1, ARB_OWN_COP);
      cyc(1'b1, 1'b1, 1'b0, 32'h66666666, 1'b0, ARB_OWN_COP);
      cyc(1'b1, 1'b0, 1'b0, 32'h77777777, 1'b0, ARB_OWN_CPU);
      cyc(1'b0, 1'b0, 1'b0, 32'h88888888, 1'b0, ARB_OWN_NONE);

      // Asynchronous reset while COP owns a stalled transaction.
      do_reset("reset4");
      sel_fp = 1'b0;
      cyc(1'b0, 1'b1, 1'b1, 32'h0, 1'b0, ARB_OWN_COP);
      cpu_cen = 1'b1; cop_cen = 1'b1; mem_stall = 1'b1; mem_rdata = 32'h12345678;
      #2;
      g_resetn = 1'b0;
      #1;
      check_idle("async_rst");
      cpu_cen = 1'b0; cop_cen = 1'b0;
      #2;
      g_resetn = 1'b1;
      sb.delete();
      m_cnt = 0;
      @(posedge g_clk);
      #1;
      cyc(1'b1, 1'b1, 1'b1, 32'h0, 1'b0, ARB_OWN_CPU);
      cyc(1'b0, 1'b1, 1'b0, 32'h99999999, 1'b0, ARB_OWN_COP);
      cyc(1'b0, 1'b0, 1'b0, 32'hAAAAAAAA, 1'b0, ARB_OWN_NONE);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
